// File: rtl/ex_mem_access.sv
// EX/MEM pipeline register with the data-memory access controller.
// Holds the stage and stalls the pipeline while a load/store is outstanding.
module ex_mem_access #(
   parameter int DATA_WIDTH     = 16,
   parameter int REG_ADDR_WIDTH = 3,
   parameter int TIMEOUT_CYCLES = 15
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      i_Sig_MemRead,
   input  logic                      i_Sig_MemWrite,
   input  logic                      i_Sig_MemtoReg,
   input  logic                      i_Sig_RegWrite,
   input  logic [REG_ADDR_WIDTH-1:0] i_Write_Register,
   input  logic [DATA_WIDTH-1:0]     i_ALU_Result,
   input  logic [DATA_WIDTH-1:0]     i_Store_Data,
   input  logic                      i_Flush,
   input  logic                      i_Mem_Ack,
   input  logic [DATA_WIDTH-1:0]     i_Mem_Rdata,
   output logic                      o_Mem_Req,
   output logic                      o_Mem_We,
   output logic [DATA_WIDTH-1:0]     o_Mem_Addr,
   output logic [DATA_WIDTH-1:0]     o_Mem_Wdata,
   output logic                      o_Stall,
   output logic                      o_Mem_Err,
   output logic                      o_Sig_MemtoReg,
   output logic [DATA_WIDTH-1:0]     o_Read_Data,
   output logic [DATA_WIDTH-1:0]     o_ALU_Result,
   output logic [REG_ADDR_WIDTH-1:0] o_Write_Register,
   output logic                      o_Sig_RegWrite
);

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } state_t;

   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

   state_t                    state_q, state_d;
   logic [7:0]                cnt_q, cnt_d;
   logic                      memwrite_q, memwrite_d;
   logic                      memtoreg_q, memtoreg_d;
   logic                      regwrite_q, regwrite_d;
   logic [REG_ADDR_WIDTH-1:0] wreg_q, wreg_d;
   logic [DATA_WIDTH-1:0]     alu_q, alu_d;
   logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0]     rdata_q, rdata_d;
   logic                      err_q, err_d;
   logic                      aborted_q, aborted_d;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      memwrite_d = memwrite_q;
      memtoreg_d = memtoreg_q;
      regwrite_d = regwrite_q;
      wreg_d     = wreg_q;
      alu_d      = alu_q;
      wdata_d    = wdata_q;
      rdata_d    = rdata_q;
      err_d      = 1'b0;
      aborted_d  = aborted_q;
      unique case (state_q)
         IDLE: begin
            aborted_d = 1'b0;
            rdata_d   = '0;
            cnt_d     = '0;
            if (i_Flush) begin
               memwrite_d = 1'b0;
               memtoreg_d = 1'b0;
               regwrite_d = 1'b0;
               wreg_d     = '0;
               alu_d      = '0;
               wdata_d    = '0;
            end else begin
               // MemRead together with MemWrite is handled as a write
               memwrite_d = i_Sig_MemWrite;
               memtoreg_d = i_Sig_MemtoReg;
               regwrite_d = i_Sig_RegWrite;
               wreg_d     = i_Write_Register;
               alu_d      = i_ALU_Result;
               wdata_d    = i_Store_Data;
               if (i_Sig_MemRead || i_Sig_MemWrite) state_d = WAIT;
            end
         end
         WAIT: begin
            if (i_Mem_Ack) begin
               if (!memwrite_q) rdata_d = i_Mem_Rdata;
               state_d = IDLE;
            end else if (cnt_q == CNT_LAST) begin
               rdata_d   = '0;
               err_d     = 1'b1;
               aborted_d = 1'b1;
               state_d   = IDLE;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         memwrite_q <= 1'b0;
         memtoreg_q <= 1'b0;
         regwrite_q <= 1'b0;
         wreg_q     <= '0;
         alu_q      <= '0;
         wdata_q    <= '0;
         rdata_q    <= '0;
         err_q      <= 1'b0;
         aborted_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         memwrite_q <= memwrite_d;
         memtoreg_q <= memtoreg_d;
         regwrite_q <= regwrite_d;
         wreg_q     <= wreg_d;
         alu_q      <= alu_d;
         wdata_q    <= wdata_d;
         rdata_q    <= rdata_d;
         err_q      <= err_d;
         aborted_q  <= aborted_d;
      end
   end

   assign o_Mem_Req        = (state_q == WAIT);
   assign o_Stall          = (state_q == WAIT);
   assign o_Mem_We         = memwrite_q;
   assign o_Mem_Addr       = alu_q;
   assign o_Mem_Wdata      = wdata_q;
   assign o_Mem_Err        = err_q;
   assign o_Sig_MemtoReg   = memtoreg_q;
   assign o_Read_Data      = rdata_q;
   assign o_ALU_Result     = alu_q;
   assign o_Write_Register = wreg_q;
   // a timed-out load must never reach the register file
   assign o_Sig_RegWrite   = regwrite_q & ~o_Stall & ~aborted_q;

endmodule

// File: tb/tb_ex_mem_access.sv
// Directed self-checking bench for ex_mem_access.
// Uses TIMEOUT_CYCLES=4 so the abort path is short.
module tb_ex_mem_access;

   logic        clk = 1'b0;
   logic        rst;
   logic        mrd, mwr, m2r, rw;
   logic [2:0]  wreg;
   logic [15:0] alu, sdata;
   logic        flush, ack;
   logic [15:0] rdata;
   logic        req, we, stall, err, o_m2r, o_rw;
   logic [15:0] addr, wdata, o_rd, o_alu;
   logic [2:0]  o_wreg;

   int checks = 0;
   int errors = 0;
   int n;

   ex_mem_access #(
      .DATA_WIDTH(16), .REG_ADDR_WIDTH(3), .TIMEOUT_CYCLES(4)
   ) dut (
      .clk(clk), .rst(rst),
      .i_Sig_MemRead(mrd), .i_Sig_MemWrite(mwr),
      .i_Sig_MemtoReg(m2r), .i_Sig_RegWrite(rw),
      .i_Write_Register(wreg), .i_ALU_Result(alu),
      .i_Store_Data(sdata), .i_Flush(flush),
      .i_Mem_Ack(ack), .i_Mem_Rdata(rdata),
      .o_Mem_Req(req), .o_Mem_We(we),
      .o_Mem_Addr(addr), .o_Mem_Wdata(wdata),
      .o_Stall(stall), .o_Mem_Err(err),
      .o_Sig_MemtoReg(o_m2r), .o_Read_Data(o_rd),
      .o_ALU_Result(o_alu), .o_Write_Register(o_wreg),
      .o_Sig_RegWrite(o_rw)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic nop();
      mrd = 0; mwr = 0; m2r = 0; rw = 0; wreg = 0;
      alu = 0; sdata = 0; flush = 0; ack = 0; rdata = 0;
   endtask

   initial begin
      nop();
      rst = 1;
      step(); step();
      rst = 0;
      chk("rst_req", {31'd0, req}, 0);
      chk("rst_stall", {31'd0, stall}, 0);
      chk("rst_err", {31'd0, err}, 0);
      chk("rst_rd", {16'd0, o_rd}, 0);
      chk("rst_alu", {16'd0, o_alu}, 0);
      chk("rst_rw", {31'd0, o_rw}, 0);

      // plain ALU op
      rw = 1; wreg = 3; alu = 16'h1234;
      step(); nop();
      chk("alu_res", {16'd0, o_alu}, 32'h1234);
      chk("alu_wreg", {29'd0, o_wreg}, 3);
      chk("alu_rw", {31'd0, o_rw}, 1);
      chk("alu_stall", {31'd0, stall}, 0);
      chk("alu_req", {31'd0, req}, 0);

      // load, ack on the third edge after capture
      mrd = 1; m2r = 1; rw = 1; wreg = 5; alu = 16'h0040;
      step(); nop();
      chk("ld_stall1", {31'd0, stall}, 1);
      chk("ld_req", {31'd0, req}, 1);
      chk("ld_we", {31'd0, we}, 0);
      chk("ld_addr", {16'd0, addr}, 32'h0040);
      chk("ld_rw_stall", {31'd0, o_rw}, 0);
      step();
      chk("ld_stall2", {31'd0, stall}, 1);
      step();
      chk("ld_stall3", {31'd0, stall}, 1);
      ack = 1; rdata = 16'hBEEF;
      step(); nop();
      chk("ld_stall_end", {31'd0, stall}, 0);
      chk("ld_req_end", {31'd0, req}, 0);
      chk("ld_rd", {16'd0, o_rd}, 32'hBEEF);
      chk("ld_m2r", {31'd0, o_m2r}, 1);
      chk("ld_rw", {31'd0, o_rw}, 1);
      chk("ld_wreg", {29'd0, o_wreg}, 5);

      // store, ack on first edge
      mwr = 1; alu = 16'h0010; sdata = 16'hA5A5;
      step(); nop();
      chk("st_req", {31'd0, req}, 1);
      chk("st_we", {31'd0, we}, 1);
      chk("st_wdata", {16'd0, wdata}, 32'hA5A5);
      chk("st_addr", {16'd0, addr}, 32'h0010);
      chk("st_stall", {31'd0, stall}, 1);
      ack = 1; rdata = 16'h5555;
      step(); nop();
      chk("st_stall_end", {31'd0, stall}, 0);
      chk("st_rd", {16'd0, o_rd}, 0);
      chk("st_req_end", {31'd0, req}, 0);

      // load with no ack: 4 stall cycles then abort
      mrd = 1; m2r = 1; rw = 1; wreg = 2; alu = 16'h0080;
      step(); nop();
      n = 0;
      while (stall && n < 20) begin
         chk("to_err_low", {31'd0, err}, 0);
         n++;
         step();
      end
      chk("to_stall_cycles", n, 4);
      chk("to_err", {31'd0, err}, 1);
      chk("to_rw", {31'd0, o_rw}, 0);
      chk("to_req", {31'd0, req}, 0);
      chk("to_rd", {16'd0, o_rd}, 0);
      step();
      chk("to_err_pulse", {31'd0, err}, 0);

      // ack on the 4th edge wins over timeout
      mrd = 1; m2r = 1; rw = 1; wreg = 4; alu = 16'h0084;
      step(); nop();
      step(); step(); step();
      chk("to4_stall", {31'd0, stall}, 1);
      ack = 1; rdata = 16'h1357;
      step(); nop();
      chk("to4_err", {31'd0, err}, 0);
      chk("to4_rd", {16'd0, o_rd}, 32'h1357);
      chk("to4_rw", {31'd0, o_rw}, 1);
      chk("to4_stall_end", {31'd0, stall}, 0);

      // flush with a load presented
      flush = 1; mrd = 1; m2r = 1; rw = 1; wreg = 6; alu = 16'h0040;
      step(); nop();
      chk("fl_req", {31'd0, req}, 0);
      chk("fl_stall", {31'd0, stall}, 0);
      chk("fl_rw", {31'd0, o_rw}, 0);
      chk("fl_alu", {16'd0, o_alu}, 0);
      chk("fl_m2r", {31'd0, o_m2r}, 0);

      // flush during WAIT is ignored
      mrd = 1; m2r = 1; rw = 1; wreg = 6; alu = 16'h0044;
      step(); nop();
      flush = 1;
      step();
      chk("flw_stall", {31'd0, stall}, 1);
      chk("flw_addr", {16'd0, addr}, 32'h0044);
      ack = 1; rdata = 16'hCAFE;
      step(); nop();
      chk("flw_rd", {16'd0, o_rd}, 32'hCAFE);
      chk("flw_wreg", {29'd0, o_wreg}, 6);
      chk("flw_rw", {31'd0, o_rw}, 1);

      // reset mid-access, then a late ack
      mrd = 1; m2r = 1; rw = 1; wreg = 1; alu = 16'h0090;
      step(); nop();
      step();
      rst = 1;
      step();
      rst = 0;
      chk("rw_stall", {31'd0, stall}, 0);
      chk("rw_req", {31'd0, req}, 0);
      ack = 1; rdata = 16'hDEAD;
      step(); nop();
      chk("late_rd", {16'd0, o_rd}, 0);
      chk("late_stall", {31'd0, stall}, 0);
      chk("late_err", {31'd0, err}, 0);
      chk("late_alu", {16'd0, o_alu}, 0);
      rw = 1; wreg = 7; alu = 16'h0777;
      step(); nop();
      chk("post_alu", {16'd0, o_alu}, 32'h0777);
      chk("post_wreg", {29'd0, o_wreg}, 7);
      chk("post_rw", {31'd0, o_rw}, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ex_mem_access.md
Name: ex_mem_access

Overview:
- EX/MEM pipeline register combined with the data-memory access controller; sits directly upstream of the MEM/WB register.
- Captures EX-stage results and control, issues a req/ack handshake to data memory for loads and stores, and stalls the pipeline until the access completes or times out.
- Presents MemtoReg, Read_Data, ALU_Result, Write_Register and RegWrite to MEM/WB; RegWrite is gated to 0 while stalled.

Parameters:
- DATA_WIDTH, 16, width of ALU result, store data and load data.
- REG_ADDR_WIDTH, 3, register-file index width.
- TIMEOUT_CYCLES, 15, maximum WAIT cycles before the access is aborted (legal range 1..255).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous active-high reset.
- i_Sig_MemRead  in  1  EX instruction is a load.
- i_Sig_MemWrite  in  1  EX instruction is a store.
- i_Sig_MemtoReg  in  1  WB selects memory data.
- i_Sig_RegWrite  in  1  EX instruction writes the register file.
- i_Write_Register  in  REG_ADDR_WIDTH  destination register.
- i_ALU_Result  in  DATA_WIDTH  ALU result; memory address for loads and stores.
- i_Store_Data  in  DATA_WIDTH  store data.
- i_Flush  in  1  insert a bubble instead of capturing the EX instruction.
- i_Mem_Ack  in  1  memory completion; one-cycle pulse or level.
- i_Mem_Rdata  in  DATA_WIDTH  load data; valid when i_Mem_Ack=1.
- o_Mem_Req  out  1  access request; held high until completion or abort.
- o_Mem_We  out  1  1 = write, 0 = read; valid while o_Mem_Req=1.
- o_Mem_Addr  out  DATA_WIDTH  equals the captured ALU_Result.
- o_Mem_Wdata  out  DATA_WIDTH  captured store data.
- o_Stall  out  1  high when state=WAIT; upstream must hold.
- o_Mem_Err  out  1  one-cycle pulse on timeout abort.
- o_Sig_MemtoReg  out  1  to MEM/WB.
- o_Read_Data  out  DATA_WIDTH  to MEM/WB.
- o_ALU_Result  out  DATA_WIDTH  to MEM/WB.
- o_Write_Register  out  REG_ADDR_WIDTH  to MEM/WB.
- o_Sig_RegWrite  out  1  to MEM/WB; forced to 0 while o_Stall=1.

Behaviour:
- Reset:
  - All stage registers, o_Read_Data and the timeout counter clear to 0.
  - State goes to IDLE; o_Mem_Req, o_Stall and o_Mem_Err go to 0.
  - Reset overrides everything, including mid-access. An i_Mem_Ack arriving after reset is ignored.
- FSM states:
  - IDLE: capture on each edge.
  - WAIT: hold the stage; access outstanding.
- IDLE, each edge:
  - If i_Flush=1: capture a bubble (all control fields 0, data fields 0).
  - Otherwise: capture all i_* fields and clear o_Read_Data to 0.
  - If the captured MemRead or MemWrite is 1 (and no flush): go to WAIT, set o_Mem_Req=1, o_Mem_We=MemWrite, clear the counter.
  - If both MemRead and MemWrite are 1, treat as a write.
- WAIT, each edge:
  - No capture; i_Flush is ignored.
  - If i_Mem_Ack=1: on a read, o_Read_Data <= i_Mem_Rdata; on a write, o_Read_Data stays 0. Then o_Mem_Req <= 0 and go to IDLE.
  - Else if counter = TIMEOUT_CYCLES-1: o_Read_Data <= 0, o_Mem_Err <= 1 for one cycle, o_Sig_RegWrite suppressed for this instruction, o_Mem_Req <= 0, go to IDLE.
  - Else: counter increments.
  - Ack in the same cycle as timeout: ack wins, no error.
- i_Mem_Ack while IDLE is ignored.
- Latency:
  - Non-memory op: visible at MEM/WB inputs immediately after the capture edge.
  - Memory op: o_Stall is high for exactly k cycles, where ack is sampled k edges after capture (k≥1). Data is valid after the ack edge.
  - Back-to-back memory ops: a new capture occurs on the first IDLE edge after completion. Throughput is 1 access per k+1 cycles.
- Output mapping:
  - o_Mem_Addr and o_Mem_Wdata are the stage registers.
  - o_Sig_RegWrite = stage RegWrite & ~o_Stall & ~aborted.

Test Plan:
- ALU op (RegWrite=1, reg 3, ALU=16'h1234, no mem) -> next cycle o_ALU_Result=16'h1234, o_Write_Register=3, o_Sig_RegWrite=1, o_Stall=0, o_Mem_Req=0.
- Load addr 16'h0040, ack with Rdata=16'hBEEF after 3 edges -> o_Stall high 3 cycles, o_Sig_RegWrite=0 during stall, then o_Read_Data=16'hBEEF, o_Sig_MemtoReg=1, o_Sig_RegWrite=1.
- Store addr 16'h0010, data 16'hA5A5, ack at first edge -> o_Mem_Req=1 with o_Mem_We=1, o_Mem_Wdata=16'hA5A5 for 1 cycle, o_Read_Data=0, o_Stall 1 cycle.
- Load with no ack, TIMEOUT_CYCLES=4 -> o_Stall high 4 cycles, one-cycle o_Mem_Err, o_Sig_RegWrite=0, FSM back to IDLE. A repeat with ack on the 4th edge -> data captured, no error.
- i_Flush=1 with a load presented -> bubble captured, no o_Mem_Req. i_Flush during WAIT -> ignored, access completes normally.
- rst asserted during WAIT, then a late ack -> all outputs 0, IDLE, ack ignored; the next ALU op is captured normally.
